// File: rtl/compare_arbiter_pkg.sv
// Shared state encodings, requester ids and the grant helper for compare_arbiter.
package compare_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  localparam int CMP_COUNT_W = 8;

  // A lone request always wins; the pointer only breaks a tie.
  function automatic logic pick_requester(input logic r0, input logic r1, input logic ptr);
    logic win;
    if (r0 && r1) begin
      win = ptr;
    end else if (r1) begin
      win = REQ_ID1;
    end else begin
      win = REQ_ID0;
    end
    return win;
  endfunction

endpackage

// File: rtl/compare_arbiter_cmp_core.sv
// Purely combinational unsigned magnitude comparator; exactly one flag is high.
module cmp_core #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/compare_arbiter.sv
// Two-requester round-robin arbiter in front of a registered comparator (IDLE/CMP/RESP).
// Optional 8-bit compare counter output enabled by macro COMPARE_ARBITER_STATS_EN.
module compare_arbiter
  import compare_arbiter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             res_valid,
  output logic             res_id,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             busy
`ifdef COMPARE_ARBITER_STATS_EN
  ,
  output logic [CMP_COUNT_W-1:0] cmp_count
`endif
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             core_gt, core_lt, core_eq;
`ifdef COMPARE_ARBITER_STATS_EN
  logic [CMP_COUNT_W-1:0] count_q, count_d;
`endif

  cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
    .a  (a_q),
    .b  (b_q),
    .gt (core_gt),
    .lt (core_lt),
    .eq (core_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= REQ_ID0;
      id_q     <= REQ_ID0;
      res_id_q <= REQ_ID0;
      a_q      <= '0;
      b_q      <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b1;
`ifdef COMPARE_ARBITER_STATS_EN
      count_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      res_id_q <= res_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
`ifdef COMPARE_ARBITER_STATS_EN
      count_q  <= count_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = CMP;
      CMP:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates tied to the transitions: grant/latch, register flags, advance pointer.
  always_comb begin
    ptr_d    = ptr_q;
    id_d     = id_q;
    res_id_d = res_id_q;
    a_d      = a_q;
    b_d      = b_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
`ifdef COMPARE_ARBITER_STATS_EN
    count_d  = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          id_d = pick_requester(req0, req1, ptr_q);
          a_d  = (id_d == REQ_ID1) ? a1 : a0;
          b_d  = (id_d == REQ_ID1) ? b1 : b0;
        end
      end
      CMP: begin
        gt_d     = core_gt;
        lt_d     = core_lt;
        eq_d     = core_eq;
        res_id_d = id_q;
      end
      RESP: begin
        ptr_d = ~res_id_q;
`ifdef COMPARE_ARBITER_STATS_EN
        count_d = count_q + 8'd1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == RESP);
    ack0      = res_valid && (res_id_q == REQ_ID0);
    ack1      = res_valid && (res_id_q == REQ_ID1);
  end

  assign res_id = res_id_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;
`ifdef COMPARE_ARBITER_STATS_EN
  assign cmp_count = count_q;
`endif

endmodule
